// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and helpers for the router packet FIFO
package router_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_LSB    = 2;
  localparam int ADDR_MSB   = 1;
  localparam int ADDR_LSB   = 0;

  function automatic int len_msb(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// rtl/router_fifo_ram.sv - word storage: synchronous write, asynchronous read
module router_fifo_ram
  import router_pkg::*;
#(
  parameter int WORD_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic                      clock,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WORD_W-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WORD_W-1:0]         rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - packet-aware FIFO for one router output channel
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    soft_reset,
  input  logic                    write_enb,
  input  logic                    lfd_state,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    read_enb,
  output logic [DATA_W-1:0]       data_out,
  output logic                    rd_sop,
  output logic                    rd_eop,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow
);

  localparam int AW      = clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int RW      = DATA_W - 1;
  localparam int LEN_MSB = len_msb(DATA_W);
  localparam int LW      = LEN_MSB - LEN_LSB + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] REM_ONE  = {{(RW-1){1'b0}}, 1'b1};

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_sop_q, rd_sop_d, rd_eop_q, rd_eop_d;
  logic              overflow_q, overflow_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic              rd_fire, wr_fire, ram_we;
  logic [DATA_W:0]   rd_word;
  logic [LW-1:0]     hdr_len;

  router_fifo_ram #(
    .WORD_W (DATA_W + 1),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata ({lfd_state, data_in}),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_CNT);
  assign count       = count_q;
  assign data_out    = data_out_q;
  assign rd_sop      = rd_sop_q;
  assign rd_eop      = rd_eop_q;
  assign overflow    = overflow_q;
  assign hdr_len     = rd_word[LEN_MSB:LEN_LSB];

  always_comb begin
    rd_fire    = read_enb & ~empty;
    wr_fire    = write_enb & (~full | rd_fire);
    ram_we     = wr_fire & ~soft_reset;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    rd_sop_d   = rd_sop_q;
    rd_eop_d   = rd_eop_q;
    overflow_d = overflow_q;
    rem_d      = rem_q;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      data_out_d = '0;
      rd_sop_d   = 1'b0;
      rd_eop_d   = 1'b0;
      overflow_d = 1'b0;
      rem_d      = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (write_enb & ~wr_fire) overflow_d = 1'b1;
      if (wr_fire & ~rd_fire) count_d = count_q + CNT_ONE;
      else if (rd_fire & ~wr_fire) count_d = count_q - CNT_ONE;
      if (rd_fire) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        data_out_d = rd_word[DATA_W-1:0];
        // A header restarts the length count even if the previous packet was truncated.
        if (rd_word[DATA_W]) begin
          rem_d    = {1'b0, hdr_len} + REM_ONE;
          rd_sop_d = 1'b1;
          rd_eop_d = 1'b0;
        end else begin
          rd_sop_d = 1'b0;
          rd_eop_d = (rem_q == REM_ONE);
          if (rem_q != '0) rem_d = rem_q - REM_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      rd_sop_q   <= 1'b0;
      rd_eop_q   <= 1'b0;
      overflow_q <= 1'b0;
      rem_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rd_sop_q   <= rd_sop_d;
      rd_eop_q   <= rd_eop_d;
      overflow_q <= overflow_d;
      rem_q      <= rem_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - self-checking bench for router_pkt_fifo
module tb_router_pkt_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 14;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn, soft_reset, write_enb, lfd_state, read_enb;
  logic [7:0] data_in, data_out;
  logic       rd_sop, rd_eop, full, empty, almost_full, overflow;
  logic [4:0] count;

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14)) u_dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
    .lfd_state(lfd_state), .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
    .rd_sop(rd_sop), .rd_eop(rd_eop), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow)
  );

  logic        b_we, b_lfd, b_re;
  logic [15:0] b_din, b_dout;
  logic        b_sop, b_eop, b_full, b_empty, b_af, b_ovf;
  logic [5:0]  b_count;

  router_pkt_fifo #(.DATA_W(16), .DEPTH(32), .AF_LEVEL(30)) u_dut_w (
    .clock(clock), .resetn(resetn), .soft_reset(1'b0), .write_enb(b_we),
    .lfd_state(b_lfd), .data_in(b_din), .read_enb(b_re), .data_out(b_dout),
    .rd_sop(b_sop), .rd_eop(b_eop), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .count(b_count), .overflow(b_ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a queue plus packet-length bookkeeping.
  logic [8:0] mq[$];
  logic [7:0] m_dout;
  bit         m_sop, m_eop, m_ovf;
  int         m_rem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_sop = 0; m_eop = 0; m_ovf = 0; m_rem = 0;
  endtask

  task automatic model_step(input bit sr, input bit we, input bit lfd,
                            input logic [7:0] din, input bit re);
    bit rd, wr;
    logic [8:0] w;
    if (sr) begin
      model_reset();
      return;
    end
    rd = re && (mq.size() > 0);
    wr = we && ((mq.size() < DEPTH) || rd);
    if (we && !wr) m_ovf = 1;
    if (rd) begin
      w = mq.pop_front();
      m_dout = w[7:0];
      if (w[8]) begin
        m_rem = int'(w[7:2]) + 1; m_sop = 1; m_eop = 0;
      end else begin
        m_sop = 0;
        m_eop = (m_rem == 1);
        if (m_rem > 0) m_rem--;
      end
    end
    if (wr) mq.push_back({lfd, din});
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_dout"},  32'(data_out),    32'(m_dout));
    chk({tag, "_sop"},   32'(rd_sop),      32'(m_sop));
    chk({tag, "_eop"},   32'(rd_eop),      32'(m_eop));
    chk({tag, "_count"}, 32'(count),       32'(mq.size()));
    chk({tag, "_full"},  32'(full),        32'(mq.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty),       32'(mq.size() == 0));
    chk({tag, "_af"},    32'(almost_full), 32'(mq.size() >= AF));
    chk({tag, "_ovf"},   32'(overflow),    32'(m_ovf));
  endtask

  task automatic step(input string tag, input bit sr, input bit we, input bit lfd,
                      input logic [7:0] din, input bit re);
    soft_reset = sr; write_enb = we; lfd_state = lfd; data_in = din; read_enb = re;
    @(posedge clock);
    model_step(sr, we, lfd, din, re);
    #1;
    soft_reset = 0; write_enb = 0; lfd_state = 0; data_in = '0; read_enb = 0;
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic wr(input string tag, input bit lfd, input logic [7:0] din);
    step(tag, 0, 1, lfd, din, 0);
  endtask

  task automatic rd(input string tag);
    step(tag, 0, 0, 0, 8'h00, 1);
  endtask

  logic [15:0] wv[7];

  initial begin
    resetn = 0; soft_reset = 0; write_enb = 0; lfd_state = 0; data_in = '0; read_enb = 0;
    b_we = 0; b_lfd = 0; b_din = '0; b_re = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check_all("reset");
    resetn = 1;
    @(negedge clock);

    // 1: header len 5 + 5 payload + parity
    wr("t1_wr", 1, 8'h14);
    for (int i = 0; i < 6; i++) wr("t1_wr", 0, 8'($urandom));
    for (int i = 0; i < 7; i++) rd("t1_rd");
    chk("t1_empty_end", 32'(empty), 32'd1);

    // 2: fill to DEPTH, then one dropped write
    for (int i = 0; i < 16; i++) wr("t2_fill", ($urandom_range(0, 3) == 0), 8'($urandom));
    chk("t2_full", 32'(full), 32'd1);
    wr("t2_drop", 0, 8'hA5);
    chk("t2_ovf", 32'(overflow), 32'd1);
    step("t2_sr", 1, 0, 0, 8'h00, 0);

    // 3: full + read + write keeps count at DEPTH with no overflow
    for (int i = 0; i < 16; i++) wr("t3_fill", 0, 8'($urandom));
    step("t3_rw", 0, 1, 1, 8'h3C, 1);
    chk("t3_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) rd("t3_drain");

    // 4: empty + read + write writes only
    step("t4_rw", 0, 1, 0, 8'h5A, 1);
    rd("t4_rd");

    // 5: soft reset mid-packet, then a clean packet
    wr("t5_wr", 1, 8'h14);
    for (int i = 0; i < 6; i++) wr("t5_wr", 0, 8'($urandom));
    for (int i = 0; i < 3; i++) rd("t5_rd");
    step("t5_sr", 1, 1, 0, 8'hFF, 1);
    wr("t5_new", 1, 8'h09);
    for (int i = 0; i < 3; i++) wr("t5_new", 0, 8'($urandom));
    for (int i = 0; i < 4; i++) rd("t5_newrd");

    // 6: asynchronous reset between edges, then a zero-length packet
    wr("t6_pre", 0, 8'hC3);
    rd("t6_pre");
    #2 resetn = 0;
    #1;
    model_reset();
    check_all("t6_async");
    @(negedge clock);
    resetn = 1;
    wr("t6_hdr0", 1, 8'h00);
    wr("t6_par", 0, 8'($urandom));
    rd("t6_rd0");
    rd("t6_rd1");
    chk("t6_eop", 32'(rd_eop), 32'd1);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 300; i++)
      step("rnd", ($urandom_range(0, 59) == 0), 1'($urandom), ($urandom_range(0, 5) == 0),
           8'($urandom), 1'($urandom));

    // Wide instance: DATA_W=16, DEPTH=32 rerun of the header+payload+parity case
    wv[0] = 16'h0014;
    for (int i = 1; i < 7; i++) wv[i] = 16'($urandom);
    for (int i = 0; i < 7; i++) begin
      b_we = 1; b_lfd = (i == 0); b_din = wv[i];
      @(posedge clock); #1;
      b_we = 0; b_lfd = 0;
      @(negedge clock);
    end
    chk("w_count", 32'(b_count), 32'd7);
    for (int i = 0; i < 7; i++) begin
      b_re = 1;
      @(posedge clock); #1;
      b_re = 0;
      @(negedge clock);
      chk("w_dout", 32'(b_dout), 32'(wv[i]));
      chk("w_sop", 32'(b_sop), 32'(i == 0));
      chk("w_eop", 32'(b_eop), 32'(i == 6));
    end
    chk("w_empty", 32'(b_empty), 32'd1);
    chk("w_ovf", 32'(b_ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
